// File: rtl/aes_inv_top.sv
// Iterative AES-128 inverse cipher: one round per clock, with round keys derived on the fly.
// A forward key expansion reaches round key 10, then the schedule is unwound as the rounds run.
module aes_inv_top #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic [127:0] out_data,
    output logic         ready,
    output logic         busy
);

    typedef enum logic [2:0] {S_IDLE, S_KEXP, S_INIT, S_ROUND, S_FINAL} state_t;

    state_t         state, state_nx;
    logic   [127:0] st;
    logic   [127:0] rk;
    logic   [3:0]   rc;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // NOTE: function locals are plain variables evaluated in order, so blocking '=' is correct here;
    // only clocked state uses '<='.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); it maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = x15;
        for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] y;
        y = gf_inv(a);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // SubWord(RotWord(w)) ^ Rcon, with the first byte of the word in bits [31:24].
    function automatic logic [31:0] key_mix(input logic [31:0] w, input logic [7:0] rcon_b);
        return {sbox(w[23:16]) ^ rcon_b, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rcon_b);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[31:0] ^ key_mix(k[127:96], rcon_b);
        n1 = n0 ^ k[63:32];
        n2 = n1 ^ k[95:64];
        n3 = n2 ^ k[127:96];
        return {n3, n2, n1, n0};
    endfunction

    function automatic logic [127:0] inv_key_expand(input logic [127:0] k, input logic [7:0] rcon_b);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[127:96] ^ k[95:64];
        p2 = k[95:64] ^ k[63:32];
        p1 = k[63:32] ^ k[31:0];
        p0 = k[31:0] ^ key_mix(p3, rcon_b);
        return {p3, p2, p1, p0};
    endfunction

    // InvSubBytes(InvShiftRows(s)): row r of column c comes from column (c - r) mod 4.
    function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[32*c+31-8*row -: 8] = inv_sbox(s[32*((c-row+4)%4)+31-8*row -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[32*c +: 32];
            r[32*c +: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // NOTE: the default assignment before the case keeps this block free of inferred latches.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_KEXP;
            S_KEXP:  if (rc == 4'(NR)) state_nx = S_INIT;
            S_INIT:  state_nx = S_ROUND;
            S_ROUND: if (rc == 4'd1) state_nx = S_FINAL;
            S_FINAL: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    // NOTE: the datapath registers are reset too, so an aborted block leaves no key or state behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= '0;
            rk       <= '0;
            rc       <= '0;
            out_data <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        st    <= data_in;
                        rk    <= key_in;
                        rc    <= 4'd1;
                        ready <= 1'b0;
                    end
                end
                S_KEXP: begin
                    rk <= key_expand(rk, rcon(rc));
                    rc <= rc + 4'd1;
                end
                S_INIT: begin
                    st <= st ^ rk;
                    rk <= inv_key_expand(rk, rcon(4'(NR)));
                    rc <= 4'(NR - 1);
                end
                S_ROUND: begin
                    st <= inv_mix_columns(inv_sub_shift(st) ^ rk);
                    rk <= inv_key_expand(rk, rcon(rc));
                    rc <= rc - 4'd1;
                end
                S_FINAL: begin
                    out_data <= inv_sub_shift(st) ^ rk;
                    ready    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_top.sv
// Directed bench for aes_inv_top: FIPS vectors, loopback against a behavioural AES encryptor,
// start-while-busy, mid-block reset and back-to-back blocks.
module tb_aes_inv_top;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic [127:0] out_data;
    logic         ready;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sbox_t [256];

    localparam logic [127:0] C1_KEY = 128'h0c0d0e0f_08090a0b_04050607_00010203;
    localparam logic [127:0] C1_CT  = 128'h70b4c55a_d8cdb780_6a7b0430_69c4e0d8;
    localparam logic [127:0] C1_PT  = 128'hccddeeff_8899aabb_44556677_00112233;
    localparam logic [127:0] B_KEY  = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
    localparam logic [127:0] B_CT   = 128'h196a0b32_dc118597_02dc09fb_3925841d;
    localparam logic [127:0] B_PT   = 128'he0370734_313198a2_885a308d_3243f6a8;

    aes_inv_top #(.NR(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .key_in   (key_in),
        .out_data (out_data),
        .ready    (ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // Forward AES-128 encryption, table driven, working on FIPS byte order.
    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rcb, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        rcb = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]] ^ rcb, sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]};
                rcb = xt(rcb);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[32*(i/4)+31-8*(i%4) -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    s[row+4*col] = t[row+4*((col+row)%4)];
            if (r != 10) begin
                for (int col = 0; col < 4; col++) begin
                    a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
                    s[4*col]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*col+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*col+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*col+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[32*(i/4)+31-8*(i%4) -: 8] = s[i];
        return res;
    endfunction

    // S-box table from the generator-3 walk over GF(2^8): p steps by *3, q by /3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ xt(p);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    // One block: start pulse, optional re-pulses while busy, bounded wait for ready.
    task automatic run_block(input logic [127:0] din, input logic [127:0] key,
                             input logic [127:0] exp, input string tag, input bit repulse);
        int n;
        bit busy_ok;
        @(negedge clk);
        data_in = din;
        key_in  = key;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = ~din;
        key_in  = ~key;
        n       = 0;
        busy_ok = 1'b1;
        while (!ready && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (repulse && (n == 3 || n == 15)) begin
                start   = 1'b1;
                data_in = {$urandom, $urandom, $urandom, $urandom};
                key_in  = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 128'(n), 128'd21);
        check({tag, "_data"}, out_data, exp);
        check({tag, "_busy_held"}, 128'(busy_ok), 128'd1);
        check({tag, "_busy_done"}, 128'(busy), 128'd0);
    endtask

    initial begin
        logic [127:0] k_r, p_r, c_r;
        logic [127:0] vk [3];
        logic [127:0] vc [3];
        logic [127:0] vp [3];
        int n;

        build_sbox();
        rst     = 1'b0;
        start   = 1'b0;
        data_in = '0;
        key_in  = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_data", out_data, 128'd0);
        check("reset_ready", 128'(ready), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        run_block(C1_CT, C1_KEY, C1_PT, "fips_c1", 1'b0);
        run_block(B_CT, B_KEY, B_PT, "fips_b", 1'b0);

        for (int i = 0; i < 50; i++) begin
            k_r = {$urandom, $urandom, $urandom, $urandom};
            p_r = {$urandom, $urandom, $urandom, $urandom};
            c_r = aes_enc(p_r, k_r);
            run_block(c_r, k_r, p_r, $sformatf("loop%0d", i), 1'b0);
            $display("Plain = 0x%032h", out_data);
        end

        run_block(C1_CT, C1_KEY, C1_PT, "busy_repulse", 1'b1);

        // Reset twelve cycles into a block clears everything at once.
        @(negedge clk);
        data_in = B_CT;
        key_in  = B_KEY;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_data", out_data, 128'd0);
        check("midrst_ready", 128'(ready), 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        run_block(C1_CT, C1_KEY, C1_PT, "after_rst", 1'b0);

        // Start held high: each result must appear 21 edges after its acceptance.
        vk[0] = C1_KEY; vc[0] = C1_CT; vp[0] = C1_PT;
        vk[1] = B_KEY;  vc[1] = B_CT;  vp[1] = B_PT;
        vk[2] = {$urandom, $urandom, $urandom, $urandom};
        vp[2] = {$urandom, $urandom, $urandom, $urandom};
        vc[2] = aes_enc(vp[2], vk[2]);
        @(negedge clk);
        data_in = vc[0];
        key_in  = vk[0];
        start   = 1'b1;
        @(posedge clk);
        #1;
        for (int kk = 0; kk < 3; kk++) begin
            n = 0;
            while (!ready && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            check($sformatf("b2b%0d_latency", kk), 128'(n), 128'd21);
            check($sformatf("b2b%0d_data", kk), out_data, vp[kk]);
            if (kk < 2) begin
                data_in = vc[kk+1];
                key_in  = vk[kk+1];
            end
            @(posedge clk);
            #1;
            check($sformatf("b2b%0d_ready_drop", kk), 128'(ready), 128'd0);
            check($sformatf("b2b%0d_hold", kk), out_data, vp[kk]);
        end
        start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
